// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional round-robin arbitration is selected with the DMEM_ARB_RR_EN macro.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DMA = 1'b1
   } gnt_e;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   // Counter preload for a given latency; out-of-range latencies are clamped
   // so the 4-bit counter can never wrap.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      int v;
      v = lat;
      if (v < MEM_LAT_MIN) v = MEM_LAT_MIN;
      if (v > MEM_LAT_MAX) v = MEM_LAT_MAX;
      return CNT_W'(v - 1);
   endfunction

endpackage

// File: rtl/dmem_arb_lat_cnt.sv
// Load/decrement latency counter with a zero flag; counts the ACCESS cycles.
module dmem_arb_lat_cnt
   import dmem_arb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load has priority, decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the
// DMA/debug loader. Each access is a fixed MEM_LAT-cycle sequence followed by
// a one-cycle DONE; the MEM stage stays stalled until its access completes.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: CPU priority).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              start_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              cpu_stall_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [31:0]       dma_wdata_i,
   output logic              dma_ack_o,
   output logic [31:0]       dma_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

   state_e            state_q, state_d;
   gnt_e              gnt_q, gnt_d;
   gnt_e              gnt_sel;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic [31:0]       dma_rdata_q, dma_rdata_d;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;

`ifdef DMEM_ARB_RR_EN
   gnt_e last_q, last_d;
   logic grant_evt;

   // Round-robin: on a conflict the port that did not win last time gets it.
   always_comb begin
      gnt_sel = GNT_CPU;
      if (cpu_req_i && dma_req_i) begin
         gnt_sel = (last_q == GNT_DMA) ? GNT_CPU : GNT_DMA;
      end else if (dma_req_i) begin
         gnt_sel = GNT_DMA;
      end
      last_d = grant_evt ? gnt_sel : last_q;
   end

   // Last-grant flop; starts at DMA so the CPU wins the first conflict.
   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         last_q <= GNT_DMA;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: the CPU wins every conflict.
   always_comb begin
      gnt_sel = cpu_req_i ? GNT_CPU : GNT_DMA;
   end
`endif

   dmem_arb_lat_cnt u_lat_cnt (
      .clk_i      (clk_i),
      .rst_ni     (start_i),
      .load_i     (cnt_load),
      .load_val_i (LAT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // FSM next state, request latching, read-data capture and memory outputs.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      dma_ack_o   = 1'b0;
`ifdef DMEM_ARB_RR_EN
      grant_evt   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (cpu_req_i || dma_req_i) begin
               gnt_d    = gnt_sel;
               cnt_load = 1'b1;
               state_d  = ACCESS;
`ifdef DMEM_ARB_RR_EN
               grant_evt = 1'b1;
`endif
               if (gnt_sel == GNT_CPU) begin
                  we_d    = cpu_we_i;
                  addr_d  = cpu_addr_i;
                  wdata_d = cpu_wdata_i;
               end else begin
                  we_d    = dma_we_i;
                  addr_d  = dma_addr_i;
                  wdata_d = dma_wdata_i;
               end
            end
         end
         ACCESS: begin
            mem_en_o    = 1'b1;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            if (cnt_zero) begin
               // Final latency cycle: single write strobe and data capture.
               mem_we_o = we_q;
               if (gnt_q == GNT_CPU) begin
                  cpu_rdata_d = mem_rdata_i;
               end else begin
                  dma_rdata_d = mem_rdata_i;
               end
               state_d = DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            dma_ack_o = (gnt_q == GNT_DMA);
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset also aborts an access.
   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   // Stall is combinational so it covers the request cycle itself.
   always_comb begin
      cpu_stall_o = cpu_req_i && !((state_q == DONE) && (gnt_q == GNT_CPU));
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign dma_rdata_o = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of per-cycle vectors for a CPU
// read and a DMA write, then hand-written conflict, abort and MEM_LAT=1 runs.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        start = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic [31:0] mem_rdata = '0;

   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
   logic        cpu_stall, dma_ack, mem_en, mem_we;
   logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
   logic        cpu_stall1, dma_ack1, mem_en1, mem_we1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_LAT(2), .ADDR_W(32)) u_dut (
      .clk_i(clk), .start_i(start),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
      .dma_wdata_i(dma_wdata), .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   dmem_arbiter #(.MEM_LAT(1), .ADDR_W(32)) u_dut1 (
      .clk_i(clk), .start_i(start),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata1), .cpu_stall_o(cpu_stall1),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
      .dma_wdata_i(dma_wdata), .dma_ack_o(dma_ack1), .dma_rdata_o(dma_rdata1),
      .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
      .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata)
   );

   typedef struct {
      logic        cr, cw;
      logic [31:0] ca, cd;
      logic        dr, dw;
      logic [31:0] da, dd, mr;
      logic        xs, xa, xe, xw;
      logic [31:0] xad, xwd, xcr, xdr;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input logic cr, cw, input logic [31:0] ca, cd,
                               input logic dr, dw, input logic [31:0] da, dd, mr,
                               input logic xs, xa, xe, xw,
                               input logic [31:0] xad, xwd, xcr, xdr);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
      v.xs = xs; v.xa = xa; v.xe = xe; v.xw = xw;
      v.xad = xad; v.xwd = xwd; v.xcr = xcr; v.xdr = xdr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ZERO;
      logic [31:0] DB;
      ZERO = 32'h0;
      DB   = 32'hDEADBEEF;

      // CPU read of 0x04 (cycles 0..4), then DMA write 0x12345678 to 0x08.
      vecs[0] = mk(1'b1,1'b0,32'h4,ZERO, 1'b0,1'b0,ZERO,ZERO, ZERO,
                   1'b1,1'b0,1'b0,1'b0, ZERO,ZERO,ZERO,ZERO);
      vecs[1] = mk(1'b1,1'b0,32'h4,ZERO, 1'b0,1'b0,ZERO,ZERO, ZERO,
                   1'b1,1'b0,1'b1,1'b0, 32'h4,ZERO,ZERO,ZERO);
      vecs[2] = mk(1'b1,1'b0,32'h4,ZERO, 1'b0,1'b0,ZERO,ZERO, DB,
                   1'b1,1'b0,1'b1,1'b0, 32'h4,ZERO,ZERO,ZERO);
      vecs[3] = mk(1'b1,1'b0,32'h4,ZERO, 1'b0,1'b0,ZERO,ZERO, ZERO,
                   1'b0,1'b0,1'b0,1'b0, ZERO,ZERO,DB,ZERO);
      vecs[4] = mk(1'b0,1'b0,ZERO,ZERO, 1'b0,1'b0,ZERO,ZERO, ZERO,
                   1'b0,1'b0,1'b0,1'b0, ZERO,ZERO,DB,ZERO);
      vecs[5] = mk(1'b0,1'b0,ZERO,ZERO, 1'b1,1'b1,32'h8,32'h12345678, ZERO,
                   1'b0,1'b0,1'b0,1'b0, ZERO,ZERO,DB,ZERO);
      vecs[6] = mk(1'b0,1'b0,ZERO,ZERO, 1'b1,1'b1,32'h8,32'h12345678, ZERO,
                   1'b0,1'b0,1'b1,1'b0, 32'h8,32'h12345678,DB,ZERO);
      vecs[7] = mk(1'b0,1'b0,ZERO,ZERO, 1'b1,1'b1,32'h8,32'h12345678, ZERO,
                   1'b0,1'b0,1'b1,1'b1, 32'h8,32'h12345678,DB,ZERO);
      vecs[8] = mk(1'b0,1'b0,ZERO,ZERO, 1'b1,1'b1,32'h8,32'h12345678, ZERO,
                   1'b0,1'b1,1'b0,1'b0, ZERO,ZERO,DB,ZERO);
      vecs[9] = mk(1'b0,1'b0,ZERO,ZERO, 1'b0,1'b0,ZERO,ZERO, ZERO,
                   1'b0,1'b0,1'b0,1'b0, ZERO,ZERO,DB,ZERO);

      // Reset state: all outputs low while start is held low.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'b0, cpu_stall}, ZERO);
      chk("rst_ack",   {31'b0, dma_ack},   ZERO);
      chk("rst_en",    {31'b0, mem_en},    ZERO);
      chk("rst_we",    {31'b0, mem_we},    ZERO);
      chk("rst_addr",  mem_addr,  ZERO);
      chk("rst_wdata", mem_wdata, ZERO);
      chk("rst_cpu_rdata", cpu_rdata, ZERO);
      chk("rst_dma_rdata", dma_rdata, ZERO);
      chk("rst_en_lat1", {31'b0, mem_en1}, ZERO);
      start = 1'b1;

      // Table-driven CPU read and DMA write.
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         cpu_req = vecs[i].cr; cpu_we = vecs[i].cw;
         cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
         dma_req = vecs[i].dr; dma_we = vecs[i].dw;
         dma_addr = vecs[i].da; dma_wdata = vecs[i].dd;
         mem_rdata = vecs[i].mr;
         @(negedge clk);
         chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].xs});
         chk($sformatf("v%0d_ack", i),   {31'b0, dma_ack},   {31'b0, vecs[i].xa});
         chk($sformatf("v%0d_en", i),    {31'b0, mem_en},    {31'b0, vecs[i].xe});
         chk($sformatf("v%0d_we", i),    {31'b0, mem_we},    {31'b0, vecs[i].xw});
         chk($sformatf("v%0d_addr", i),  mem_addr,  vecs[i].xad);
         chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].xwd);
         chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].xcr);
         chk($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].xdr);
      end

      // Simultaneous CPU read of 0x10 and DMA read of 0x20.
`ifndef DMEM_ARB_RR_EN
      for (int c = 0; c < 9; c++) begin
         next_cycle();
         cpu_req = (c < 4); cpu_we = 1'b0; cpu_addr = 32'h10;
         dma_req = (c < 8); dma_we = 1'b0; dma_addr = 32'h20;
         mem_rdata = (c == 2) ? 32'hCAFE0001 : ((c == 6) ? 32'hBEEF0002 : ZERO);
         @(negedge clk);
         case (c)
            1: chk("cf_first_addr", mem_addr, 32'h10);
            3: begin
                  chk("cf_cpu_unstall", {31'b0, cpu_stall}, ZERO);
                  chk("cf_cpu_rdata", cpu_rdata, 32'hCAFE0001);
                  chk("cf_no_ack", {31'b0, dma_ack}, ZERO);
               end
            4: chk("cf_gap_en", {31'b0, mem_en}, ZERO);
            5: chk("cf_dma_addr", mem_addr, 32'h20);
            7: begin
                  chk("cf_dma_ack", {31'b0, dma_ack}, 32'h1);
                  chk("cf_dma_rdata", dma_rdata, 32'hBEEF0002);
               end
            default: ;
         endcase
      end
`else
      for (int c = 0; c < 13; c++) begin
         next_cycle();
         cpu_req = (c < 12); cpu_we = 1'b0; cpu_addr = 32'h10;
         dma_req = (c < 12); dma_we = 1'b0; dma_addr = 32'h20;
         mem_rdata = ZERO;
         @(negedge clk);
         case (c)
            1: chk("rr_grant0", mem_addr, 32'h10);
            5: chk("rr_grant1", mem_addr, 32'h20);
            7: chk("rr_ack1", {31'b0, dma_ack}, 32'h1);
            9: chk("rr_grant2", mem_addr, 32'h10);
            default: ;
         endcase
      end
`endif

      // Reset pulsed in cycle 1 of a DMA write aborts it.
      next_cycle();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h55;
      next_cycle();
      #2;
      start = 1'b0;
      dma_req = 1'b0;
      @(negedge clk);
      chk("ab_rst_en", {31'b0, mem_en}, ZERO);
      chk("ab_rst_we", {31'b0, mem_we}, ZERO);
      @(posedge clk);
      #2;
      start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("ab_we_%0d", c),  {31'b0, mem_we},  ZERO);
         chk($sformatf("ab_ack_%0d", c), {31'b0, dma_ack}, ZERO);
         chk($sformatf("ab_en_%0d", c),  {31'b0, mem_en},  ZERO);
      end

      // MEM_LAT=1 CPU write of 0xA5A5A5A5 to 0x40.
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         cpu_req = (c < 3); cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hA5A5A5A5;
         @(negedge clk);
         case (c)
            0: begin
                  chk("l1_c0_stall", {31'b0, cpu_stall1}, 32'h1);
                  chk("l1_c0_we", {31'b0, mem_we1}, ZERO);
               end
            1: begin
                  chk("l1_c1_we", {31'b0, mem_we1}, 32'h1);
                  chk("l1_c1_addr", mem_addr1, 32'h40);
                  chk("l1_c1_wdata", mem_wdata1, 32'hA5A5A5A5);
                  chk("l1_c1_stall", {31'b0, cpu_stall1}, 32'h1);
               end
            2: begin
                  chk("l1_c2_stall", {31'b0, cpu_stall1}, ZERO);
                  chk("l1_c2_we", {31'b0, mem_we1}, ZERO);
               end
            default: chk("l1_c3_en", {31'b0, mem_en1}, ZERO);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
